// File: rtl/sync_rom.sv
// 256-entry sine lookup ROM with a registered 16-bit signed output.
// Stores one quarter wave; the other three quadrants come from mirror and negation.
module sync_rom (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  address,
    output logic [15:0] sine_out
);

    logic [6:0]  idx;
    logic [14:0] mag;
    logic [15:0] value;

    // Quarter-wave magnitudes round(32767*sin(2*pi*i/256)) for i = 0..64
    function automatic logic [14:0] quarter(input logic [6:0] i);
        logic [14:0] q;
        case (i)
            7'd0:  q = 15'd0;
            7'd1:  q = 15'd804;
            7'd2:  q = 15'd1608;
            7'd3:  q = 15'd2410;
            7'd4:  q = 15'd3212;
            7'd5:  q = 15'd4011;
            7'd6:  q = 15'd4808;
            7'd7:  q = 15'd5602;
            7'd8:  q = 15'd6393;
            7'd9:  q = 15'd7179;
            7'd10: q = 15'd7962;
            7'd11: q = 15'd8739;
            7'd12: q = 15'd9512;
            7'd13: q = 15'd10278;
            7'd14: q = 15'd11039;
            7'd15: q = 15'd11793;
            7'd16: q = 15'd12539;
            7'd17: q = 15'd13279;
            7'd18: q = 15'd14010;
            7'd19: q = 15'd14732;
            7'd20: q = 15'd15446;
            7'd21: q = 15'd16151;
            7'd22: q = 15'd16846;
            7'd23: q = 15'd17530;
            7'd24: q = 15'd18204;
            7'd25: q = 15'd18868;
            7'd26: q = 15'd19519;
            7'd27: q = 15'd20159;
            7'd28: q = 15'd20787;
            7'd29: q = 15'd21403;
            7'd30: q = 15'd22005;
            7'd31: q = 15'd22594;
            7'd32: q = 15'd23170;
            7'd33: q = 15'd23731;
            7'd34: q = 15'd24279;
            7'd35: q = 15'd24811;
            7'd36: q = 15'd25329;
            7'd37: q = 15'd25832;
            7'd38: q = 15'd26319;
            7'd39: q = 15'd26790;
            7'd40: q = 15'd27245;
            7'd41: q = 15'd27683;
            7'd42: q = 15'd28105;
            7'd43: q = 15'd28510;
            7'd44: q = 15'd28898;
            7'd45: q = 15'd29268;
            7'd46: q = 15'd29621;
            7'd47: q = 15'd29956;
            7'd48: q = 15'd30273;
            7'd49: q = 15'd30571;
            7'd50: q = 15'd30852;
            7'd51: q = 15'd31113;
            7'd52: q = 15'd31356;
            7'd53: q = 15'd31580;
            7'd54: q = 15'd31785;
            7'd55: q = 15'd31971;
            7'd56: q = 15'd32137;
            7'd57: q = 15'd32285;
            7'd58: q = 15'd32412;
            7'd59: q = 15'd32521;
            7'd60: q = 15'd32609;
            7'd61: q = 15'd32678;
            7'd62: q = 15'd32728;
            7'd63: q = 15'd32757;
            7'd64: q = 15'd32767;
            default: q = 15'd0;
        endcase
        return q;
    endfunction

    // Odd quadrants read the quarter table backwards; the upper half is negated
    always_comb begin
        idx = {1'b0, address[5:0]};
        if (address[6])
            idx = 7'd64 - {1'b0, address[5:0]};
        mag = quarter(idx);
        value = {1'b0, mag};
        if (address[7])
            value = 16'd0 - {1'b0, mag};
    end

    always_ff @(posedge clock) begin
        if (reset)
            sine_out <= 16'd0;
        else
            sine_out <= value;
    end

endmodule

// File: tb/tb_sync_rom.sv
// Scoreboard bench for sync_rom: driver queues expected samples, monitor checks them.
module tb_sync_rom;

    logic        clock;
    logic        reset;
    logic [7:0]  address;
    logic [15:0] sine_out;

    typedef struct {
        logic [15:0] exp;
        int          addr;
        bit          rst;
        string       name;
    } item_t;

    item_t sb[$];
    int    checks;
    int    failures;
    bit    req_valid;
    logic [15:0] obs[256];
    bit    seen[256];

    sync_rom dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .sine_out(sine_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: direct evaluation of the sine formula, ties rounded away from zero
    function automatic logic [15:0] model(input int k);
        real r;
        int  v;
        r = 32767.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
        if (r >= 0.0)
            v = $rtoi(r + 0.5);
        else
            v = -$rtoi(0.5 - r);
        return 16'(v);
    endfunction

    task automatic issue(input int a, input bit r,
                         input logic [15:0] e, input string n);
        item_t it;
        @(negedge clock);
        address = 8'(a);
        reset = r;
        req_valid = 1'b1;
        it.exp = e;
        it.addr = a;
        it.rst = r;
        it.name = n;
        sb.push_back(it);
    endtask

    task automatic rd(input int a, input string n);
        issue(a, 1'b0, model(a), n);
    endtask

    // Monitor: a request accepted on a rising edge is visible by the next falling edge
    initial begin
        bit    took;
        item_t it;
        forever begin
            @(posedge clock);
            took = req_valid;
            @(negedge clock);
            if (took) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL underflow: output 0x%04h with no expectation",
                             sine_out);
                end else begin
                    it = sb.pop_front();
                    if (sine_out !== it.exp) begin
                        failures++;
                        $display("FAIL %s addr=%0d rst=%0b: got %0d want %0d",
                                 it.name, it.addr, it.rst,
                                 $signed(sine_out), $signed(it.exp));
                    end
                    if (!it.rst) begin
                        obs[it.addr] = sine_out;
                        seen[it.addr] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int a;
        int budget;
        checks = 0;
        failures = 0;
        req_valid = 1'b0;
        reset = 1'b1;
        address = 8'd64;
        foreach (seen[i]) seen[i] = 1'b0;

        issue(64, 1'b1, 16'd0, "reset_hold");
        issue(64, 1'b1, 16'd0, "reset_hold");
        issue(64, 1'b0, 16'd32767, "reset_release");

        issue(0,   1'b0, 16'd0, "latency");
        issue(64,  1'b0, 16'd32767, "latency");
        issue(128, 1'b0, 16'd0, "latency");
        issue(192, 1'b0, 16'hFFFF - 16'd32766, "latency");

        issue(16,  1'b0, 16'd12539, "anchor");
        issue(32,  1'b0, 16'd23170, "anchor");
        issue(96,  1'b0, 16'd23170, "anchor");
        issue(160, 1'b0, 16'd0 - 16'd23170, "anchor");
        issue(255, 1'b0, 16'd0 - 16'd804, "anchor");

        for (int k = 0; k < 256; k++)
            rd(k, "sweep");

        issue(255, 1'b0, 16'd0 - 16'd804, "wrap");
        issue(0,   1'b0, 16'd0, "wrap");

        for (int k = 90; k < 110; k++) begin
            if (k == 100)
                issue(k, 1'b1, 16'd0, "mid_reset");
            else
                rd(k, "mid_stream");
        end

        for (int n = 0; n < 300; n++) begin
            a = int'($urandom_range(255));
            if ($urandom_range(15) == 0)
                issue(a, 1'b1, 16'd0, "rand_reset");
            else
                rd(a, "random");
        end

        @(negedge clock);
        req_valid = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(negedge clock);
            budget++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        for (int k = 0; k < 128; k++) begin
            if (seen[k] && seen[k + 128]) begin
                checks++;
                if (obs[k + 128] !== 16'd0 - obs[k]) begin
                    failures++;
                    $display("FAIL symmetry k=%0d: got %0d want %0d", k,
                             $signed(obs[k + 128]), -$signed(obs[k]));
                end
            end
        end
        for (int k = 0; k < 256; k++) begin
            if (seen[k]) begin
                checks++;
                if (obs[k] === 16'h8000) begin
                    failures++;
                    $display("FAIL range k=%0d: got -32768 want > -32768", k);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
